// File: rtl/cajero_pkg.sv
// Shared types and constants for the ATM transaction controller.
package cajero_pkg;

    localparam int unsigned PIN_DIGITS = 4;
    localparam int unsigned BALANCE_W  = 64;

    localparam logic TRANS_DEPOSITO = 1'b0;
    localparam logic TRANS_RETIRO   = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StPinEntry,
        StWaitTipo,
        StWaitMonto,
        StBloqueo
    } estado_t;

endpackage

// File: rtl/pin_capture.sv
// Shifts in keyed BCD digits and flags the strobe that completes a full PIN.
module pin_capture
    import cajero_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clr,
    input  logic                      i_stb,
    input  logic [3:0]                i_digito,
    output logic                      o_pin_listo,
    output logic [4*PIN_DIGITS-1:0]   o_pin_valor
);

    localparam int unsigned CW = $clog2(PIN_DIGITS);

    logic [4*PIN_DIGITS-1:0] r_buffer;
    logic [CW-1:0]           r_cuenta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buffer <= '0;
            r_cuenta <= '0;
        end else if (i_clr) begin
            r_buffer <= '0;
            r_cuenta <= '0;
        end else if (i_stb) begin
            r_buffer <= o_pin_valor;
            // Counter wraps to zero on the last digit, ready for a retry.
            r_cuenta <= r_cuenta + 1'b1;
        end
    end

    assign o_pin_valor = {r_buffer[4*PIN_DIGITS-5:0], i_digito};
    assign o_pin_listo = i_stb && (r_cuenta == CW'(PIN_DIGITS - 1));

endmodule

// File: rtl/cajero_ctrl.sv
// ATM session FSM: card, PIN check with lockout, transaction type, amount, balance update.
module cajero_ctrl
    import cajero_pkg::*;
#(
    parameter logic [63:0]  BALANCE_INICIAL = 64'd10000,
    parameter int unsigned  MAX_INTENTOS    = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  TARJETA_RECIBIDA,
    input  logic [15:0]           PIN,
    input  logic [3:0]            DIGITO,
    input  logic                  DIGITO_STB,
    input  logic                  TIPO_TRANS,
    input  logic                  TIPO_STB,
    input  logic [31:0]           MONTO,
    input  logic                  MONTO_STB,
    output logic                  BALANCE_ACTUALIZADO,
    output logic                  ENTREGAR_DINERO,
    output logic                  FONDOS_INSUFICIENTES,
    output logic                  PIN_INCORRECTO,
    output logic                  ADVERTENCIA,
    output logic                  BLOQUEO,
    output logic [BALANCE_W-1:0]  BALANCE
);

    localparam int unsigned IW = $clog2(MAX_INTENTOS + 1);

    estado_t              r_estado;
    logic                 r_tipo;
    logic [IW-1:0]        r_intentos;
    logic [BALANCE_W-1:0] r_balance;
    logic                 r_actualizado;
    logic                 r_entregar;
    logic                 r_fondos_insuf;
    logic                 r_pin_incorrecto;
    logic                 r_advertencia;
    logic                 r_bloqueo;

    logic                 w_clr;
    logic                 w_dig_stb;
    logic                 w_pin_listo;
    logic [15:0]          w_pin_valor;
    logic [IW-1:0]        w_intentos_inc;
    logic [BALANCE_W-1:0] w_monto_ext;
    logic                 w_fondos_ok;

    assign w_clr          = (r_estado == StIdle) && TARJETA_RECIBIDA;
    assign w_dig_stb      = (r_estado == StPinEntry) && DIGITO_STB;
    assign w_intentos_inc = r_intentos + 1'b1;
    assign w_monto_ext    = {{(BALANCE_W - 32){1'b0}}, MONTO};
    assign w_fondos_ok    = (w_monto_ext <= r_balance);

    pin_capture u_pin_capture (
        .i_clk       (Clk),
        .i_rst_n     (Reset),
        .i_clr       (w_clr),
        .i_stb       (w_dig_stb),
        .i_digito    (DIGITO),
        .o_pin_listo (w_pin_listo),
        .o_pin_valor (w_pin_valor)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_estado         <= StIdle;
            r_tipo           <= TRANS_DEPOSITO;
            r_intentos       <= '0;
            r_balance        <= BALANCE_INICIAL;
            r_actualizado    <= 1'b0;
            r_entregar       <= 1'b0;
            r_fondos_insuf   <= 1'b0;
            r_pin_incorrecto <= 1'b0;
            r_advertencia    <= 1'b0;
            r_bloqueo        <= 1'b0;
        end else begin
            r_actualizado    <= 1'b0;
            r_entregar       <= 1'b0;
            r_fondos_insuf   <= 1'b0;
            r_pin_incorrecto <= 1'b0;
            unique case (r_estado)
                StIdle: begin
                    if (TARJETA_RECIBIDA) begin
                        r_estado      <= StPinEntry;
                        r_intentos    <= '0;
                        r_advertencia <= 1'b0;
                    end
                end
                StPinEntry: begin
                    if (w_pin_listo) begin
                        if (w_pin_valor == PIN) begin
                            r_estado      <= StWaitTipo;
                            r_intentos    <= '0;
                            r_advertencia <= 1'b0;
                        end else begin
                            r_intentos <= w_intentos_inc;
                            // The locking attempt raises BLOQUEO instead of a wrong-PIN pulse.
                            if (w_intentos_inc == IW'(MAX_INTENTOS)) begin
                                r_estado  <= StBloqueo;
                                r_bloqueo <= 1'b1;
                            end else begin
                                r_pin_incorrecto <= 1'b1;
                            end
                            if (w_intentos_inc == IW'(2)) begin
                                r_advertencia <= 1'b1;
                            end
                        end
                    end
                end
                StWaitTipo: begin
                    if (TIPO_STB) begin
                        r_tipo   <= TIPO_TRANS;
                        r_estado <= StWaitMonto;
                    end
                end
                StWaitMonto: begin
                    if (MONTO_STB) begin
                        r_estado <= StIdle;
                        if (r_tipo == TRANS_DEPOSITO) begin
                            r_balance     <= r_balance + w_monto_ext;
                            r_actualizado <= 1'b1;
                        end else if (w_fondos_ok) begin
                            r_balance     <= r_balance - w_monto_ext;
                            r_actualizado <= 1'b1;
                            r_entregar    <= 1'b1;
                        end else begin
                            r_fondos_insuf <= 1'b1;
                        end
                    end
                end
                StBloqueo: begin
                    r_bloqueo <= 1'b1;
                end
                default: begin
                    r_estado <= StIdle;
                end
            endcase
        end
    end

    assign BALANCE_ACTUALIZADO  = r_actualizado;
    assign ENTREGAR_DINERO      = r_entregar;
    assign FONDOS_INSUFICIENTES = r_fondos_insuf;
    assign PIN_INCORRECTO       = r_pin_incorrecto;
    assign ADVERTENCIA          = r_advertencia;
    assign BLOQUEO              = r_bloqueo;
    assign BALANCE              = r_balance;

endmodule

// File: tb/tb_cajero_ctrl.sv
// Scoreboard bench for cajero_ctrl: stimulus queues expected pulse events, a monitor pops them.
`timescale 1ns/1ps
module tb_cajero_ctrl;

    typedef struct packed {
        logic [3:0]  pul;   // {ACTUALIZADO, ENTREGAR, FONDOS_INSUF, PIN_INCORRECTO}
        logic        adv;
        logic        bloq;
        logic [63:0] bal;
    } evento_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        TARJETA_RECIBIDA = 1'b0;
    logic [15:0] PIN = 16'h1234;
    logic [3:0]  DIGITO = 4'd0;
    logic        DIGITO_STB = 1'b0;
    logic        TIPO_TRANS = 1'b0;
    logic        TIPO_STB = 1'b0;
    logic [31:0] MONTO = 32'd0;
    logic        MONTO_STB = 1'b0;
    logic        BALANCE_ACTUALIZADO;
    logic        ENTREGAR_DINERO;
    logic        FONDOS_INSUFICIENTES;
    logic        PIN_INCORRECTO;
    logic        ADVERTENCIA;
    logic        BLOQUEO;
    logic [63:0] BALANCE;

    int      n_vec = 0;
    int      n_err = 0;
    evento_t cola[$];

    cajero_ctrl #(
        .BALANCE_INICIAL (64'd5000),
        .MAX_INTENTOS    (3)
    ) dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .TARJETA_RECIBIDA     (TARJETA_RECIBIDA),
        .PIN                  (PIN),
        .DIGITO               (DIGITO),
        .DIGITO_STB           (DIGITO_STB),
        .TIPO_TRANS           (TIPO_TRANS),
        .TIPO_STB             (TIPO_STB),
        .MONTO                (MONTO),
        .MONTO_STB            (MONTO_STB),
        .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
        .ENTREGAR_DINERO      (ENTREGAR_DINERO),
        .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES),
        .PIN_INCORRECTO       (PIN_INCORRECTO),
        .ADVERTENCIA          (ADVERTENCIA),
        .BLOQUEO              (BLOQUEO),
        .BALANCE              (BALANCE)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nombre, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nombre, act, act, req, req);
        end
    endtask

    task automatic esperar(input logic [3:0] pul, input logic adv, input logic [63:0] bal);
        evento_t e;
        e.pul  = pul;
        e.adv  = adv;
        e.bloq = 1'b0;
        e.bal  = bal;
        cola.push_back(e);
    endtask

    task automatic tarjeta();
        @(negedge Clk); TARJETA_RECIBIDA = 1'b1;
        @(negedge Clk); TARJETA_RECIBIDA = 1'b0;
    endtask

    task automatic digito(input logic [3:0] d);
        @(negedge Clk); DIGITO = d; DIGITO_STB = 1'b1;
        @(negedge Clk); DIGITO_STB = 1'b0;
    endtask

    task automatic pin4(input logic [15:0] p);
        for (int i = 0; i < 4; i++) digito(p[15-4*i -: 4]);
    endtask

    task automatic tipo(input logic t);
        @(negedge Clk); TIPO_TRANS = t; TIPO_STB = 1'b1;
        @(negedge Clk); TIPO_STB = 1'b0;
    endtask

    task automatic monto(input logic [31:0] m);
        @(negedge Clk); MONTO = m; MONTO_STB = 1'b1;
        @(negedge Clk); MONTO_STB = 1'b0;
    endtask

    // Monitor: every pulse cycle must match the oldest queued expectation.
    initial begin
        evento_t act;
        evento_t req;
        forever begin
            @(negedge Clk);
            act = {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO,
                   ADVERTENCIA, BLOQUEO, BALANCE};
            if (Reset && (act.pul != 4'b0000)) begin
                if (cola.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pulso_inesperado: got pulses %b bal %0d, expected none",
                             act.pul, act.bal);
                end else begin
                    req = cola.pop_front();
                    check("evento", act, req);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation bound expired, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge Clk);
        check("reset_pulsos", {60'd0, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
                               PIN_INCORRECTO}, 64'd0);
        check("reset_adv", {63'd0, ADVERTENCIA}, 64'd0);
        check("reset_bloq", {63'd0, BLOQUEO}, 64'd0);
        check("reset_bal", BALANCE, 64'd5000);
        Reset = 1'b1;

        // Deposit 1500: 5000 -> 6500
        tarjeta(); pin4(16'h1234); tipo(1'b0);
        esperar(4'b1000, 1'b0, 64'd6500);
        monto(32'd1500);

        // Strobes in IDLE are ignored
        monto(32'd50); tipo(1'b1); digito(4'd1);
        check("idle_ignora_bal", BALANCE, 64'd6500);

        // Withdraw exactly the balance
        tarjeta(); pin4(16'h1234); tipo(1'b1);
        esperar(4'b1100, 1'b0, 64'd0);
        monto(32'd6500);

        // Withdraw 1 from zero: refused
        tarjeta(); pin4(16'h1234); tipo(1'b1);
        esperar(4'b0010, 1'b0, 64'd0);
        monto(32'd1);

        // Two wrong PINs then the right one
        tarjeta();
        esperar(4'b0001, 1'b0, 64'd0);
        pin4(16'h1235);
        esperar(4'b0001, 1'b1, 64'd0);
        pin4(16'h1235);
        check("adv_tras_dos", {63'd0, ADVERTENCIA}, 64'd1);
        pin4(16'h1234);
        check("adv_tras_ok", {63'd0, ADVERTENCIA}, 64'd0);
        monto(32'd999);  // ignored in WAIT_TIPO
        tipo(1'b0);
        esperar(4'b1000, 1'b0, 64'd7);
        monto(32'd7);

        // Three wrong PINs lock the card
        tarjeta();
        esperar(4'b0001, 1'b0, 64'd7);
        pin4(16'h9999);
        esperar(4'b0001, 1'b1, 64'd7);
        pin4(16'h1111);
        pin4(16'h4321);
        check("bloqueo_on", {63'd0, BLOQUEO}, 64'd1);
        check("bloqueo_sin_pin_inc", {63'd0, PIN_INCORRECTO}, 64'd0);
        tarjeta(); pin4(16'h1234); tipo(1'b0); monto(32'd100);
        check("bloqueo_sigue", {63'd0, BLOQUEO}, 64'd1);
        check("bloqueo_bal", BALANCE, 64'd7);

        // Reset releases the lock and restores the balance
        @(negedge Clk); Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset2_bloq", {63'd0, BLOQUEO}, 64'd0);
        check("reset2_adv", {63'd0, ADVERTENCIA}, 64'd0);
        check("reset2_bal", BALANCE, 64'd5000);
        Reset = 1'b1;

        tarjeta(); pin4(16'h1234); tipo(1'b0);
        esperar(4'b1000, 1'b0, 64'd5100);
        monto(32'd100);

        repeat (3) @(negedge Clk);
        check("cola_vacia", 64'(cola.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
